led_pattern_gen: RTL and testbench

Multi-channel LED pattern generator driven by the internal oscillator clock. It is the parametrised successor to the single-toggle board blinker. Each of N_CH channels has its own mode (off / on / blink / breathe) and an 8-bit-class PWM brightness level, programmed through a valid/ready config port. Out of reset, all channels blink in phase at full level, so a bare board still shows LED activity with no host attached.

---
 rtl/led_pattern_gen.sv | 147 ++++++++++++++
 tb/tb_led_pattern_gen.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: OFF / ON / BLINK / BREATHE per channel, shared PWM.
// Define LED_BREATHE_EN to build the BREATHE ramp; without it mode 3 behaves as ON.
module led_pattern_gen #(
  parameter int          N_CH      = 4,
  parameter int          PWM_BITS  = 8,
  parameter int          TICK_BITS = 27,
  parameter logic [1:0]  RST_MODE  = 2'd2,
  localparam int         CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                osc_clk,
  input  logic                RST_N,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_level,
  output logic                cfg_err,
  output logic                tick,
  output logic [N_CH-1:0]     led
);

  // state | meaning
  // IDLE  | ready to accept a config write
  // APPLY | previous write being applied; cfg_ready low for this cycle
  typedef enum logic {IDLE, APPLY} cfg_state_t;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_ON      = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_BREATHE = 2'd3;

  cfg_state_t           state, state_nxt;
  logic [TICK_BITS-1:0] presc;
  logic [PWM_BITS-1:0]  pwm_cnt;
  logic [1:0]           mode  [N_CH];
  logic [PWM_BITS-1:0]  level [N_CH];
  logic [PWM_BITS-1:0]  duty  [N_CH];
  logic [N_CH-1:0]      phase;
  logic [N_CH-1:0]      wr;
  logic [N_CH-1:0]      led_nxt;
  logic                 accept;
  logic                 ch_ok;

  always_ff @(posedge osc_clk or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    if (state == IDLE && cfg_valid) state_nxt = APPLY;
  end

  always_comb begin
    cfg_ready = (state == IDLE);
  end

  assign accept = cfg_valid && cfg_ready;
  assign ch_ok  = 32'(cfg_ch) < 32'(N_CH);

  always_comb begin
    for (int i = 0; i < N_CH; i++) wr[i] = accept && ch_ok && (cfg_ch == CH_W'(i));
  end

  always_ff @(posedge osc_clk or negedge RST_N) begin
    if (!RST_N) begin
      presc   <= '0;
      pwm_cnt <= '0;
      tick    <= 1'b0;
      cfg_err <= 1'b0;
      led     <= '0;
    end else begin
      presc   <= presc + TICK_BITS'(1);
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      tick    <= (presc == '1);
      cfg_err <= accept && !ch_ok;
      led     <= led_nxt;
    end
  end

  // A write to a channel overrides its tick advance in the same cycle.
  always_ff @(posedge osc_clk or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < N_CH; i++) begin
        mode[i]  <= RST_MODE;
        level[i] <= '1;
      end
      phase <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (wr[i]) begin
          mode[i]  <= cfg_mode;
          level[i] <= cfg_level;
          phase[i] <= 1'b0;
        end else if (tick) begin
          phase[i] <= ~phase[i];
        end
      end
    end
  end

`ifdef LED_BREATHE_EN
  logic [PWM_BITS-1:0] ramp [N_CH];
  logic [N_CH-1:0]     dir_dn;

  always_ff @(posedge osc_clk or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < N_CH; i++) ramp[i] <= '0;
      dir_dn <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (wr[i]) begin
          ramp[i]   <= '0;
          dir_dn[i] <= 1'b0;
        end else if (tick && mode[i] == MODE_BREATHE && level[i] != '0) begin
          if (!dir_dn[i]) begin
            ramp[i] <= ramp[i] + PWM_BITS'(1);
            if (ramp[i] + PWM_BITS'(1) == level[i]) dir_dn[i] <= 1'b1;
          end else begin
            ramp[i] <= ramp[i] - PWM_BITS'(1);
            if (ramp[i] - PWM_BITS'(1) == '0) dir_dn[i] <= 1'b0;
          end
        end
      end
    end
  end
`endif

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      duty[i] = '0;
      case (mode[i])
        MODE_OFF:     duty[i] = '0;
        MODE_ON:      duty[i] = level[i];
        MODE_BLINK:   duty[i] = phase[i] ? level[i] : '0;
`ifdef LED_BREATHE_EN
        MODE_BREATHE: duty[i] = ramp[i];
`else
        MODE_BREATHE: duty[i] = level[i];
`endif
        default:      duty[i] = '0;
      endcase
      led_nxt[i] = pwm_cnt < duty[i];
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomized bench for led_pattern_gen: a 4-channel and a 3-channel instance share one
// config stream and are compared every cycle against a tick-count based reference model.
`timescale 1ns/1ps
module tb_led_pattern_gen;

  localparam int PB  = 4;
  localparam int TKB = 4;
  localparam int PWM_M  = 1 << PB;
  localparam int TICK_M = 1 << TKB;

  logic       osc_clk = 1'b0;
  logic       RST_N = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [1:0] cfg_mode = '0;
  logic [3:0] cfg_level = '0;
  logic       rdy4, rdy3, err4, err3, tick4, tick3;
  logic [3:0] led4;
  logic [2:0] led3;

  int total = 0;
  int bad = 0;

  // reference state; instance 0 = N_CH 4, instance 1 = N_CH 3
  int       nch [2] = '{4, 3};
  int       m_mode [2][4];
  int       m_lvl  [2][4];
  int       m_t    [2][4];
  bit [3:0] m_led [2];
  bit       m_err [2];
  bit       m_tick, m_ready;
  int       m_presc, m_pwm;

  always #5 osc_clk = ~osc_clk;

  led_pattern_gen #(.N_CH(4), .PWM_BITS(PB), .TICK_BITS(TKB), .RST_MODE(2'd2)) dut4 (
    .osc_clk(osc_clk), .RST_N(RST_N), .cfg_valid(cfg_valid), .cfg_ready(rdy4),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_level(cfg_level), .cfg_err(err4),
    .tick(tick4), .led(led4));

  led_pattern_gen #(.N_CH(3), .PWM_BITS(PB), .TICK_BITS(TKB), .RST_MODE(2'd2)) dut3 (
    .osc_clk(osc_clk), .RST_N(RST_N), .cfg_valid(cfg_valid), .cfg_ready(rdy3),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_level(cfg_level), .cfg_err(err3),
    .tick(tick3), .led(led3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // breathe brightness after t ticks: triangle wave 0..l..0 with period 2l
  function automatic int ramp_of(input int t, input int l);
    int r;
    if (l == 0) return 0;
    r = t % (2 * l);
    return (r <= l) ? r : 2 * l - r;
  endfunction

  function automatic int duty_of(input int md, input int l, input int t);
    case (md)
      0: return 0;
      1: return l;
      2: return (t % 2 == 1) ? l : 0;
`ifdef LED_BREATHE_EN
      default: return ramp_of(t, l);
`else
      default: return l;
`endif
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        m_mode[k][i] = 2;
        m_lvl[k][i]  = PWM_M - 1;
        m_t[k][i]    = 0;
      end
      m_led[k] = '0;
      m_err[k] = 1'b0;
    end
    m_tick = 1'b0; m_ready = 1'b1; m_presc = 0; m_pwm = 0;
  endtask

  // called at a falling edge: check current cycle, drive inputs, advance model one cycle
  task automatic cyc(input bit v, input int ch, input int md, input int lv);
    bit       acc;
    bit [3:0] ln [2];
    chk("led4", 32'(led4), 32'(m_led[0]));
    chk("led3", 32'(led3), 32'(m_led[1][2:0]));
    chk("tick4", 32'(tick4), 32'(m_tick));
    chk("tick3", 32'(tick3), 32'(m_tick));
    chk("ready4", 32'(rdy4), 32'(m_ready));
    chk("ready3", 32'(rdy3), 32'(m_ready));
    chk("err4", 32'(err4), 32'(m_err[0]));
    chk("err3", 32'(err3), 32'(m_err[1]));
    cfg_valid = v;
    cfg_ch    = ch[1:0];
    cfg_mode  = md[1:0];
    cfg_level = lv[3:0];
    acc = v && m_ready;
    for (int k = 0; k < 2; k++) begin
      ln[k] = '0;
      for (int i = 0; i < nch[k]; i++)
        ln[k][i] = m_pwm < duty_of(m_mode[k][i], m_lvl[k][i], m_t[k][i]);
      for (int i = 0; i < nch[k]; i++) begin
        if (acc && ch == i) begin
          m_mode[k][i] = md; m_lvl[k][i] = lv; m_t[k][i] = 0;
        end else if (m_tick) begin
          m_t[k][i]++;
        end
      end
      m_err[k] = acc && (ch >= nch[k]);
      m_led[k] = ln[k];
    end
    m_tick  = (m_presc == TICK_M - 1);
    m_presc = (m_presc + 1) % TICK_M;
    m_pwm   = (m_pwm + 1) % PWM_M;
    m_ready = !acc;
    @(negedge osc_clk);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) cyc(1'b0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge osc_clk);
    RST_N = 1'b1;

    idle(80);                        // default blink at full level
    cyc(1'b1, 1, 1, 4); idle(40);    // ch1 ON level 4
    cyc(1'b1, 2, 3, 3); idle(220);   // ch2 BREATHE level 3

    for (int n = 0; n < 40 && !(m_tick && m_ready); n++) cyc(1'b0, 0, 0, 0);
    chk("tick_align", 32'(tick4), 32'd1);
    cyc(1'b1, 0, 0, 9); idle(60);    // ch0 OFF together with a tick

    cyc(1'b1, 0, 1, 7); cyc(1'b1, 3, 3, 5); cyc(1'b1, 3, 3, 5); idle(40);  // back-to-back, ch3 out of range for dut3
    cyc(1'b1, 2, 3, 0); idle(40);    // breathe at level 0
    cyc(1'b1, 1, 3, 15); idle(600);  // full-range breathe

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 19) == 0)
        cyc(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
      else
        cyc(1'b0, 0, 0, 0);
    end

    idle(21);
    RST_N = 1'b0;
    cfg_valid = 1'b0;
    #1;
    chk("rst_led4", 32'(led4), 32'd0);
    chk("rst_led3", 32'(led3), 32'd0);
    chk("rst_tick", 32'(tick4), 32'd0);
    chk("rst_ready", 32'(rdy4), 32'd1);
    chk("rst_err", 32'(err4), 32'd0);
    @(negedge osc_clk);
    @(negedge osc_clk);
    model_reset();
    RST_N = 1'b1;
    idle(80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
